// File: rtl/axis2obuf.sv
// AXI4-Stream slave that packs 64-bit beats into a 72-bit outbound buffer and
// publishes whole frames by advancing committed_prod; bad frames are rewound.
module axis2obuf #(
   parameter int AW = 10,
   parameter int DW = 72
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [63:0]   tdat,
   input  logic [7:0]    tkep,
   input  logic          tval,
   input  logic          tlst,
   output logic          trdy,
   output logic [AW:0]   committed_prod,
   input  logic [AW:0]   committed_cons,
   output logic [AW-1:0] wr_addr,
   output logic [DW-1:0] wr_data,
   output logic          wr_en,
   output logic          drop
);

   typedef enum logic {S_ACCEPT, S_DROP} state_t;

   localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};
   localparam logic [AW:0] FLEN_MAX = {1'b0, {AW{1'b1}}};

   state_t      state;
   logic [AW:0] wr_ptr;
   logic [AW:0] flen;

   logic full;
   logic in_acc;
   logic hs;
   logic good;
   logic bad;
   logic over;

   // Full when the producer is a whole buffer ahead of the consumer.
   assign full   = (wr_ptr[AW] != committed_cons[AW]) &&
                   (wr_ptr[AW-1:0] == committed_cons[AW-1:0]);
   assign in_acc = (state == S_ACCEPT);
   assign trdy   = !rst && (!in_acc || !full);
   assign hs     = tval && trdy;
   assign good   = hs && in_acc && tkep[0];
   assign bad    = hs && in_acc && !tkep[0];
   // A frame that would need more than MAXW words is cut before its MAXW-th word.
   assign over   = good && !tlst && (flen == FLEN_MAX);

   assign wr_en   = good && !over;
   assign wr_addr = wr_ptr[AW-1:0];
   assign wr_data = wr_en ? {tdat, tkep[7:1], tlst} : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= S_ACCEPT;
         wr_ptr         <= '0;
         committed_prod <= '0;
         flen           <= '0;
         drop           <= 1'b0;
      end else begin
         drop <= bad || over;
         if (bad || over) begin
            // Rewind to the last committed frame end; uncommitted words are abandoned.
            wr_ptr <= committed_prod;
            flen   <= '0;
            state  <= (bad && tlst) ? S_ACCEPT : S_DROP;
         end else if (wr_en) begin
            wr_ptr <= wr_ptr + PTR_ONE;
            if (tlst) begin
               committed_prod <= wr_ptr + PTR_ONE;
               flen           <= '0;
            end else begin
               flen <= flen + PTR_ONE;
            end
         end else if (!in_acc && hs && tlst) begin
            state <= S_ACCEPT;
         end
      end
   end

endmodule

// File: doc/axis2obuf.md
# axis2obuf

Outbound counterpart of the inbound buffer reader: an AXI4-Stream slave that accepts 64-bit frames from the user side and writes them into the outbound dual-port buffer that feeds the MAC transmit engine. Frames become visible to the consumer only once complete, by advancing `committed_prod`; the consumer returns space through `committed_cons`. Oversized or malformed frames are discarded without ever being committed.

## Interface
- `AW`, 10: buffer address width; capacity MAXW = 2^AW words.
- `DW`, 72: buffer word width; fixed at 72.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `tdat`  in  64  AXIS data; byte 0 in [7:0].
- `tkep`  in  8  AXIS byte enables.
- `tval`  in  1  AXIS valid.
- `tlst`  in  1  AXIS last beat of frame.
- `trdy`  out  1  AXIS ready.
- `committed_prod`  out  AW+1  write pointer of the last committed frame end; the MSB is the wrap bit.
- `committed_cons`  in  AW+1  consumer pointer; the slot below it is free.
- `wr_addr`  out  AW  buffer write address.
- `wr_data`  out  DW  buffer write data.
- `wr_en`  out  1  buffer write strobe.
- `drop`  out  1  one-cycle pulse per discarded frame.

## Operation
- Word format:
  - `wr_data[71:8]` = `tdat`.
  - `wr_data[7:1]` = `tkep[7:1]`.
  - `wr_data[0]` = `tlst`.
  - `tkep[0]` is implied 1.
- Internal registers:
  - `wr_ptr` [AW:0]: next write slot.
  - `flen`: words written in the current frame, AW+1 bits.
  - `state` ∈ {ACCEPT, DROP}.
- Pointer arithmetic is modulo 2^(AW+1).
  - used = `wr_ptr` − `committed_cons`.
  - full when used == MAXW, i.e. MSBs differ and low AW bits are equal.
- ACCEPT:
  - `trdy` = !full.
  - A beat is accepted when `tval && trdy`.
  - Good beat: `wr_en`=1, `wr_addr`=`wr_ptr[AW-1:0]`, `wr_ptr`++, `flen`++.
  - If `tlst`: `committed_prod` ← `wr_ptr`+1, `flen` ← 0.
- Malformed beat (`tkep[0]`==0):
  - No write; `wr_ptr` ← `committed_prod`; `flen` ← 0; `drop` pulses.
  - If `tlst`=0, go to DROP; if `tlst`=1, stay in ACCEPT.
- Oversize (accepted good beat with `tlst`=0 and `flen` == MAXW−1):
  - The beat is not written.
  - `wr_ptr` ← `committed_prod`, `flen` ← 0, `drop` pulses, go to DROP.
  - A frame of exactly MAXW words with `tlst` on the last word is legal.
- DROP:
  - `trdy`=1 unconditionally, `wr_en`=0.
  - Beats are consumed and discarded.
  - The `tlst` beat returns the block to ACCEPT.
- Only `committed_prod` is visible to the consumer; uncommitted words can be overwritten by a rewind.

## Timing
- Reset (asynchronous assert):
  - `trdy`=0, `wr_en`=0, `drop`=0.
  - `wr_ptr`=0, `committed_prod`=0, `flen`=0, `state`=ACCEPT.
  - `wr_addr`=0, `wr_data`=0.
- First cycle after deassert: `trdy`=1, provided `committed_cons`==0.
- `trdy` is combinational from registered state and `committed_cons`. It never depends on `tval`.
- Write path:
  - `wr_en`, `wr_addr` and `wr_data` are combinational in the handshake cycle.
  - The buffer captures on the same edge as the handshake; zero latency.
- Commit latency: `committed_prod` updates on the edge that accepts the `tlst` beat and is visible the following cycle.
- `drop` asserts in the cycle after the offending beat's handshake, for exactly one cycle.
- Consumer release: a change on `committed_cons` affects full in the same cycle.
- Full and consumer release in the same cycle: the freed space is usable immediately.
- Wrap-around: `wr_addr` wraps MAXW−1 → 0; the pointer MSB toggles.
- Reset mid-frame: the partial frame is lost and `committed_prod` returns to 0. The consumer must be reset together with this block.
- Throughput: one beat per cycle whenever not full.

## Test plan
- AW=4; a 3-beat frame with last `tkep`=0x0F and `committed_cons`=0.
  - Required: writes at addresses 0,1,2.
  - Required: `wr_data[7:0]` of the last word = 0x0F.
  - Required: `committed_prod` = 3 one cycle after the last handshake.
- AW=4; back-to-back 16-word frames with `committed_cons` held at 0.
  - Required: the first frame is accepted and `committed_prod`=16 (0x10).
  - Required: `trdy`=0 on the next cycle.
  - Set `committed_cons`=0x10: `trdy`=1 in the same cycle; the next write lands at address 0 with `wr_ptr`=0x11 afterwards.
- AW=4; a 17-beat frame.
  - Required: 15 writes, then `drop`=1 for one cycle.
  - Required: remaining beats accepted with `wr_en`=0.
  - Required: `committed_prod` unchanged; the next good frame starts at the old `committed_prod`.
- A frame whose 2nd beat has `tkep`=0xFE (no `tlst`).
  - Required: one `drop` pulse and beats discarded until `tlst`.
  - Required: the following frame writes over the rewound slots.
- `rst` asserted mid-frame, after 2 beats.
  - Required: `trdy`=0 asynchronously and `committed_prod`=0.
  - Required: after release, a new frame writes from address 0.
- Random `tval` gaps with 10^4 frames and a consumer model.
  - Required: every committed frame read back matches what was sent.
  - Required: no write ever lands in the unconsumed region.
